pipelined_cla_adder_3op: RTL and testbench

//  Parametrised, pipelined three-operand adder: in1 + in2 + in3 + cin, unsigned.

---
 rtl/pipelined_cla_adder_3op.sv | 183 ++++++++++++++++++
 tb/tb_pipelined_cla_adder_3op.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_3op.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder_3op
//
// Two-stage pipelined unsigned three-operand adder: {cout,sum} = in1+in2+in3+cin.
// Stage 1 is a 3:2 carry-save compressor. Stage 2 is a grouped carry-lookahead
// adder that resolves the sum and carry vectors from stage 1. Both stages are
// registered and stall under a valid/ready handshake. Up to two operand sets
// can be in flight, and results leave in strict FIFO order.
//
// Parameters
//   WIDTH  operand width; must be >= 4 and a multiple of GROUP
//   GROUP  CLA group size in bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set on in1/in2/in3/cin is valid
//   in_ready   block accepts an operand set this cycle (combinational)
//   in1..in3   unsigned operands, WIDTH bits each
//   cin        carry-in, weight 2^0
//   out_valid  sum/cout hold a valid result (registered)
//   out_ready  downstream accepts the result this cycle
//   sum        result bits [WIDTH-1:0] (registered)
//   cout       result bits [WIDTH+1:WIDTH] (registered)
// -----------------------------------------------------------------------------
module pipelined_cla_adder_3op #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [1:0]       cout
);

    localparam int NG = WIDTH / GROUP;

    // Stage registers
    logic [WIDTH-1:0] s1_s_reg;
    logic [WIDTH:0]   s1_c_reg;
    logic             s1_v_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [1:0]       cout_reg;
    logic             out_valid_reg;

    // Handshake: a stage moves when the stage after it can take its contents
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_v_reg || s2_adv;
    assign in_ready = s1_adv;

    // -------------------------------------------------------------------------
    // Stage 1: carry-save compression. The carry vector is shifted up one bit
    // and cin rides in its free LSB, so stage 2 needs no separate carry-in.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] s1_s_next;
    logic [WIDTH:0]   s1_c_next;

    assign s1_s_next = in1 ^ in2 ^ in3;
    assign s1_c_next = {(in1 & in2) | (in1 & in3) | (in2 & in3), cin};

    // -------------------------------------------------------------------------
    // Stage 2: grouped CLA of s1_s + s1_c[WIDTH-1:0]; s1_c[WIDTH] has weight
    // 2^WIDTH and is folded into cout together with the adder's carry-out.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] sum_next;
    logic [1:0]       cout_next;

    assign op_a  = s1_s_reg;
    assign op_b  = s1_c_reg[WIDTH-1:0];
    assign bit_g = op_a & op_b;
    assign bit_p = op_a ^ op_b;

    // Group generate: carry leaves the group regardless of its carry-in
    function automatic logic grp_generate(input logic [GROUP-1:0] g_in,
                                          input logic [GROUP-1:0] p_in);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            acc = g_in[i] | (p_in[i] & acc);
        end
        return acc;
    endfunction

    // Carries into each bit of a group, given the group's carry-in
    function automatic logic [GROUP-1:0] grp_carries(input logic [GROUP-1:0] g_in,
                                                     input logic [GROUP-1:0] p_in,
                                                     input logic             c_in);
        logic [GROUP-1:0] c;
        c[0] = c_in;
        for (int i = 1; i < GROUP; i++) begin
            c[i] = g_in[i-1] | (p_in[i-1] & c[i-1]);
        end
        return c;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_group
            assign grp_g[gi] = grp_generate(bit_g[gi*GROUP +: GROUP], bit_p[gi*GROUP +: GROUP]);
            assign grp_p[gi] = &bit_p[gi*GROUP +: GROUP];
            assign sum_next[gi*GROUP +: GROUP] =
                bit_p[gi*GROUP +: GROUP] ^
                grp_carries(bit_g[gi*GROUP +: GROUP], bit_p[gi*GROUP +: GROUP], grp_c[gi]);
        end
    endgenerate

    // Lookahead between groups: each group carry is the OR of every lower
    // group's generate, qualified by the propagates of the groups in between.
    // The carry into group 0 is zero because cin already sits in op_b[0].
    always_comb begin
        logic lc;
        logic pp;
        grp_c    = '0;
        grp_c[0] = 1'b0;
        for (int k = 0; k < NG; k++) begin
            lc = 1'b0;
            for (int j = 0; j <= k; j++) begin
                pp = 1'b1;
                for (int m = j + 1; m <= k; m++) begin
                    pp = pp & grp_p[m];
                end
                lc = lc | (grp_g[j] & pp);
            end
            grp_c[k+1] = lc;
        end
    end

    // Two weight-2^WIDTH bits (adder carry-out and the top carry-save bit)
    assign cout_next = {grp_c[NG] & s1_c_reg[WIDTH], grp_c[NG] ^ s1_c_reg[WIDTH]};

    // -------------------------------------------------------------------------
    // Pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_s_reg      <= '0;
            s1_c_reg      <= '0;
            s1_v_reg      <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v_reg <= in_valid;
                // Data only loads on a transfer; idle bubbles leave it untouched
                if (in_valid) begin
                    s1_s_reg <= s1_s_next;
                    s1_c_reg <= s1_c_next;
                end
            end
            if (s2_adv) begin
                out_valid_reg <= s1_v_reg;
                if (s1_v_reg) begin
                    sum_reg  <= sum_next;
                    cout_reg <= cout_next;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_pipelined_cla_adder_3op.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder_3op
//
// Drives three instances (WIDTH/GROUP = 8/4, 16/4, 32/8) from one shared
// stimulus; each instance sees the low WIDTH bits of the operands. A
// scoreboard per instance holds expected results computed with plain integer
// arithmetic and checks every output transfer in order.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder_3op;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b, c;
    logic        cin;

    logic        ir8, ov8;
    logic [7:0]  s8;
    logic [1:0]  c8;
    logic        ir16, ov16;
    logic [15:0] s16;
    logic [1:0]  c16;
    logic        ir32, ov32;
    logic [31:0] s32;
    logic [1:0]  c32;

    always #5 clk = ~clk;

    pipelined_cla_adder_3op #(.WIDTH(8), .GROUP(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .in1(a[7:0]), .in2(b[7:0]), .in3(c[7:0]), .cin(cin),
        .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(c8));

    pipelined_cla_adder_3op #(.WIDTH(16), .GROUP(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .in1(a[15:0]), .in2(b[15:0]), .in3(c[15:0]), .cin(cin),
        .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(c16));

    pipelined_cla_adder_3op #(.WIDTH(32), .GROUP(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .in1(a), .in2(b), .in3(c), .cin(cin),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(c32));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact unsigned sum of the low w bits of each operand plus cin
    function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z,
                                          input logic ci);
        logic [33:0] m;
        m = (w >= 32) ? 34'h0_FFFF_FFFF : ((34'd1 << w) - 34'd1);
        return ({2'b0, x} & m) + ({2'b0, y} & m) + ({2'b0, z} & m) + {33'd0, ci};
    endfunction

    logic [33:0] q8[$];
    logic [33:0] q16[$];
    logic [33:0] q32[$];

    // Scoreboard: sample mid-cycle what will transfer at the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && ir8)  q8.push_back(model(8, a, b, c, cin));
            if (in_valid && ir16) q16.push_back(model(16, a, b, c, cin));
            if (in_valid && ir32) q32.push_back(model(32, a, b, c, cin));
            if (ov8 && out_ready) begin
                if (q8.size() == 0) check("sb8_unexpected", {33'd0, ov8}, 34'd0);
                else                check("sb8", {24'd0, c8, s8}, q8.pop_front());
            end
            if (ov16 && out_ready) begin
                if (q16.size() == 0) check("sb16_unexpected", {33'd0, ov16}, 34'd0);
                else                 check("sb16", {16'd0, c16, s16}, q16.pop_front());
            end
            if (ov32 && out_ready) begin
                if (q32.size() == 0) check("sb32_unexpected", {33'd0, ov32}, 34'd0);
                else                 check("sb32", {c32, s32}, q32.pop_front());
            end
        end
    end

    // Present one set on an idle pipeline; lat counts rising edges until out_valid
    task automatic apply_one(input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] z, input logic ci, output int lat);
        a = x; b = y; c = z; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!ov16 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic        ci;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int gaps;
        int stalls;
        int stale;
        logic [17:0] held;
        logic [31:0] sa0, sb0, sc0;
        logic        sci0;

        vecs[0] = '{16'h0001, 16'h0002, 16'h0003, 1'b0, 18'h00006};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 18'h2FFFE};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b1, 18'h10000};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 18'h00000};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b1, 18'h00001};
        vecs[5] = '{16'h8000, 16'h8000, 16'h8000, 1'b0, 18'h18000};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 18'h1FFFE};
        vecs[7] = '{16'h1234, 16'h1111, 16'h0F0F, 1'b1, 18'h03255};
        vecs[8] = '{16'h00FF, 16'h0001, 16'h0000, 1'b0, 18'h00100};
        vecs[9] = '{16'h0FFF, 16'h0000, 16'h0000, 1'b1, 18'h01000};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {33'd0, ov16}, 34'd0);
        check("rst_result16", {16'd0, c16, s16}, 34'd0);
        check("rst_result8_32", {c8, s8, c32, s32[23:0]}, 34'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {33'd0, ir16}, 34'd1);

        // Directed vectors, one at a time on an idle pipeline
        for (int i = 0; i < 10; i++) begin
            apply_one({16'd0, vecs[i].x}, {16'd0, vecs[i].y}, {16'd0, vecs[i].z}, vecs[i].ci, lat);
            check($sformatf("vec%0d_lat", i), 34'(lat), 34'd2);
            check($sformatf("vec%0d_result", i), {16'd0, c16, s16}, {16'd0, vecs[i].exp});
        end

        // Maximum operands at the other widths
        apply_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
        check("w8_max", {24'd0, c8, s8}, 34'h2FE);
        check("w32_max", {c32, s32}, 34'h2_FFFF_FFFE);
        apply_one(32'h0000_00FF, 32'd0, 32'd0, 1'b1, lat);
        check("w8_wrap", {24'd0, c8, s8}, 34'h100);

        // Full-rate random streaming
        gaps = 0; stalls = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; c = $urandom; cin = 1'($urandom_range(0, 1));
            if (!ir16) stalls++;
            @(posedge clk); #1;
            if (i >= 1 && !ov16) gaps++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stream_gaps", 34'(gaps), 34'd0);
        check("stream_stalls", 34'(stalls), 34'd0);
        check("stream_drained", 34'(q16.size() + q8.size() + q32.size()), 34'd0);

        // Random valid/ready traffic
        for (int i = 0; i < 600; i++) begin
            a = $urandom; b = $urandom; c = $urandom; cin = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("random_drained", 34'(q16.size() + q8.size() + q32.size()), 34'd0);

        // Backpressure: three sets against a stalled output
        out_ready = 1'b0;
        sa0 = 32'h0000_A5A5; sb0 = 32'h0000_5A5A; sc0 = 32'h0000_FFFF; sci0 = 1'b1;
        a = sa0; b = sb0; c = sc0; cin = sci0; in_valid = 1'b1;
        check("bp_ready_set0", {33'd0, ir16}, 34'd1);
        @(posedge clk); #1;
        a = 32'h0000_1357; b = 32'h0000_2468; c = 32'h0000_0F0F; cin = 1'b0;
        check("bp_ready_set1", {33'd0, ir16}, 34'd1);
        @(posedge clk); #1;
        a = 32'h0000_FFFF; b = 32'h0000_0001; c = 32'h0000_8000; cin = 1'b1;
        check("bp_ready_full", {33'd0, ir16}, 34'd0);
        check("bp_out_valid", {33'd0, ov16}, 34'd1);
        held = {c16, s16};
        check("bp_held_value", {16'd0, held}, model(16, sa0, sb0, sc0, sci0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_stable%0d", i), {15'd0, ov16, c16, s16}, {15'd0, 1'b1, held});
            check($sformatf("bp_still_full%0d", i), {33'd0, ir16}, 34'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {33'd0, ir16}, 34'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", 34'(q16.size() + q8.size() + q32.size()), 34'd0);

        // Reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'h1111_1111; b = 32'h2222_2222; c = 32'h3333_3333; cin = 1'b1;
        @(posedge clk); #1;
        a = 32'h4444_4444;
        @(posedge clk); #1;
        check("mid_rst_full", {32'd0, ov16, ir16}, 34'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, ov8, ov16, ov32}, 34'd0);
        check("mid_rst_sum16", {16'd0, c16, s16}, 34'd0);
        check("mid_rst_sum32", {c32, s32}, 34'd0);
        q8.delete(); q16.delete(); q32.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        check("post_rst_ready", {33'd0, ir16}, 34'd1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ov8 || ov16 || ov32) stale++;
        end
        check("post_rst_no_stale", 34'(stale), 34'd0);

        // Pipeline is usable again after reset
        apply_one(32'd1, 32'd2, 32'd3, 1'b0, lat);
        check("post_rst_lat", 34'(lat), 34'd2);
        check("post_rst_result", {16'd0, c16, s16}, 34'h6);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
